// File: rtl/s_pea_out_collector.sv
// -----------------------------------------------------------------------------
// s_pea_out_collector
//
// Streaming-mode sink at the PE-array output edge. It captures result tokens
// from one PE output port and drives the array-wide advance enable
// (pea_ready_o), so that every token is captured exactly once. Captured tokens
// are buffered in a small circular FIFO and forwarded on a valid/ready master
// stream that carries a last marker. A word count latched at start bounds each
// run, and done_o pulses once the final word has left on the stream.
//
// Ports:
//   clk_i        clock
//   rst_n_i      asynchronous active-low reset
//   start_i      start a run (only honoured in IDLE)
//   n_words_i    number of tokens in the run (latched on start)
//   pe_valid_i   PE output valid (held high while the array is stalled)
//   pe_res_i     PE output result
//   pea_ready_o  array advance enable, fanned out to every PE
//   m_valid_o    stream data valid
//   m_data_o     stream data (FIFO head)
//   m_last_o     final word of the run
//   m_ready_i    downstream ready
//   busy_o       high whenever the collector is not IDLE
//   done_o       one-cycle pulse at the end of a run
// -----------------------------------------------------------------------------
module s_pea_out_collector #(
  parameter int N_BITS = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  n_words_i,
  input  logic              pe_valid_i,
  input  logic [N_BITS-1:0] pe_res_i,
  output logic              pea_ready_o,
  output logic              m_valid_o,
  output logic [N_BITS-1:0] m_data_o,
  output logic              m_last_o,
  input  logic              m_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FCNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [FCNT_W:0]   DEPTH_EXT = (FCNT_W + 1)'(DEPTH);
  localparam logic [FCNT_W-1:0] DEPTH_CNT = FCNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   n_words_reg;
  logic [CNT_W-1:0]   cap_cnt_reg;
  logic [CNT_W-1:0]   pop_cnt_reg;
  logic [FCNT_W-1:0]  fifo_cnt_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  // pea_ready_o as seen at the previous edge: the PE output only changes on an
  // edge where ready was high, so rdy_reg==1 means the token on pe_res_i is new.
  logic               rdy_reg;
  logic [N_BITS-1:0]  mem_reg [DEPTH];

  logic               in_run;
  logic               start_fire;
  logic               cap;
  logic               pop;
  logic               last_word;
  logic [CNT_W:0]     cap_cnt_after;
  logic [FCNT_W:0]    fifo_after;

  assign in_run     = (state_reg == S_RUN);
  assign start_fire = (state_reg == S_IDLE) && start_i;

  assign cap = in_run && pe_valid_i && rdy_reg && (cap_cnt_reg < n_words_reg);

  // Ready reserves room for the token the array will produce in response to
  // this ready (it lands next cycle). A concurrent pop is deliberately not
  // credited, which keeps the reservation conservative and overflow-free.
  assign cap_cnt_after = {1'b0, cap_cnt_reg} + {{CNT_W{1'b0}}, cap};
  assign fifo_after    = {1'b0, fifo_cnt_reg} + {{FCNT_W{1'b0}}, cap};
  assign pea_ready_o   = in_run
                         && (cap_cnt_after < {1'b0, n_words_reg})
                         && (fifo_after < DEPTH_EXT);

  assign m_valid_o = (fifo_cnt_reg != '0);
  // Gated so the (unreset) storage never shows through while empty.
  assign m_data_o  = m_valid_o ? mem_reg[rd_ptr_reg] : '0;
  assign pop       = m_valid_o && m_ready_i;
  assign last_word = (pop_cnt_reg == (n_words_reg - CNT_W'(1)));
  assign m_last_o  = m_valid_o && last_word;

  assign busy_o = (state_reg != S_IDLE);
  assign done_o = (state_reg == S_DONE);

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (start_i) begin
          state_next = (n_words_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // The capturing cycle itself already drops ready, so leave now.
        if (cap && (cap_cnt_after == {1'b0, n_words_reg})) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && last_word) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Control state, counters and FIFO bookkeeping
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg    <= S_IDLE;
      n_words_reg  <= '0;
      cap_cnt_reg  <= '0;
      pop_cnt_reg  <= '0;
      fifo_cnt_reg <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      rdy_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (start_fire) begin
        n_words_reg <= n_words_i;
        cap_cnt_reg <= '0;
        pop_cnt_reg <= '0;
        rdy_reg     <= 1'b0;
      end else begin
        rdy_reg <= pea_ready_o;
        if (cap) cap_cnt_reg <= cap_cnt_reg + CNT_W'(1);
        if (pop) pop_cnt_reg <= pop_cnt_reg + CNT_W'(1);
      end

      if (cap) begin
        wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
      end

      // Push and pop together leave the occupancy unchanged.
      if (cap && !pop) begin
        fifo_cnt_reg <= fifo_cnt_reg + FCNT_W'(1);
      end else if (pop && !cap) begin
        fifo_cnt_reg <= fifo_cnt_reg - FCNT_W'(1);
      end
    end
  end

  // FIFO storage: plain array, written at the tail, read combinationally at
  // the head so a token can appear on the stream the cycle after capture.
  always_ff @(posedge clk_i) begin
    if (cap) begin
      mem_reg[wr_ptr_reg] <= pe_res_i;
    end
  end

  // The ready reservation makes a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(cap && (fifo_cnt_reg == DEPTH_CNT)));

endmodule

// File: tb/tb_s_pea_out_collector.sv
// -----------------------------------------------------------------------------
// Testbench for s_pea_out_collector.
//
// The bench plays the PE array: whenever pea_ready_o is high at a clock edge
// the array advances and presents a new output (valid with some probability);
// otherwise it holds its previous output, including a held-high valid.
// The reference model is a token-conservation view: every valid token the
// array produces during a run must leave the stream exactly once, in order,
// the run must produce exactly n_words tokens, last marks word n_words-1 and
// done follows the final pop by one cycle.
// -----------------------------------------------------------------------------
module tb_s_pea_out_collector;

  localparam int N_BITS = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              start_i = 1'b0;
  logic [CNT_W-1:0]  n_words_i = '0;
  logic              pe_valid_i = 1'b0;
  logic [N_BITS-1:0] pe_res_i = '0;
  logic              m_ready_i = 1'b0;
  logic              pea_ready_o;
  logic              m_valid_o;
  logic [N_BITS-1:0] m_data_o;
  logic              m_last_o;
  logic              busy_o;
  logic              done_o;

  s_pea_out_collector #(
    .N_BITS(N_BITS),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .start_i    (start_i),
    .n_words_i  (n_words_i),
    .pe_valid_i (pe_valid_i),
    .pe_res_i   (pe_res_i),
    .pea_ready_o(pea_ready_o),
    .m_valid_o  (m_valid_o),
    .m_data_o   (m_data_o),
    .m_last_o   (m_last_o),
    .m_ready_i  (m_ready_i),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [N_BITS-1:0] exp_q[$];     // tokens produced by the array, not yet streamed out
  logic [N_BITS-1:0] forced_q[$];  // directed token values, consumed before random ones
  int                produced;
  int                popped;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pea_ready"}, pea_ready_o, 0);
    chk({tag, "_m_valid"},   m_valid_o,   0);
    chk({tag, "_m_data"},    m_data_o,    0);
    chk({tag, "_m_last"},    m_last_o,    0);
    chk({tag, "_busy"},      busy_o,      0);
    chk({tag, "_done"},      done_o,      0);
  endtask

  // Array advance: new output, valid with probability valid_pct.
  task automatic pe_advance(input int valid_pct);
    if (int'($urandom_range(99)) < valid_pct) begin
      pe_valid_i = 1'b1;
      if (forced_q.size() != 0) pe_res_i = forced_q.pop_front();
      else                      pe_res_i = $urandom;
      exp_q.push_back(pe_res_i);
      produced++;
    end else begin
      pe_valid_i = 1'b0;
      pe_res_i   = $urandom;
    end
  endtask

  function automatic logic pick_ready(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  // One run. stall: cycles with m_ready_i forced low at the start.
  // restart_at: cycle at which a spurious start with another count is pulsed.
  // abort_at: cycle at which reset is asserted mid-run (run then ends).
  // prod_at/prod_exp: expected number of produced tokens at cycle prod_at.
  task automatic run(input int n, input int valid_pct, input int ready_pct,
                     input int stall, input int restart_at, input int abort_at,
                     input int prod_at, input int prod_exp);
    bit rdy_s, exp_done, got_done, aborted;
    int cyc;
    rdy_s = 0; got_done = 0; aborted = 0; cyc = 0;
    exp_done = (n == 0);
    exp_q.delete();
    produced = 0;
    popped   = 0;

    @(posedge clk_i); #1;
    start_i   = 1'b1;
    n_words_i = CNT_W'(n);
    @(posedge clk_i); #1;
    start_i   = 1'b0;
    m_ready_i = (stall > 0) ? 1'b0 : pick_ready(ready_pct);

    while (!got_done && cyc < 600) begin
      @(negedge clk_i);
      if (cyc == abort_at) begin
        chk("pre_abort_valid", m_valid_o, 1);
        rst_n_i = 1'b0;
        #1;
        check_all_zero("abort");
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        exp_q.delete();
        aborted = 1;
        break;
      end
      rdy_s = pea_ready_o;
      chk("busy", busy_o, 1);
      chk("done", done_o, exp_done);
      if (done_o) got_done = 1;
      exp_done = 0;
      // The array must never be advanced past the run's token budget.
      chk("over_advance", pea_ready_o && (produced >= n), 0);
      if (cyc == prod_at) begin
        chk("produced_at_stall", produced, prod_exp);
        chk("ready_low_when_full", pea_ready_o, 0);
      end
      if (m_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", m_data_o, 'x);
        end else begin
          chk("data", m_data_o, exp_q[0]);
          chk("last", m_last_o, (popped == n - 1));
        end
        if (m_ready_i) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          popped++;
          if (popped == n) exp_done = 1;
        end
      end else begin
        chk("last_without_valid", m_last_o, 0);
      end
      if (got_done) break;

      @(posedge clk_i); #1;
      if (rdy_s) pe_advance(valid_pct);
      start_i   = (cyc + 1 == restart_at);
      n_words_i = start_i ? CNT_W'(n + 3) : n_words_i;
      m_ready_i = (cyc + 1 < stall) ? 1'b0 : pick_ready(ready_pct);
      cyc++;
    end
    start_i = 1'b0;

    if (!aborted) begin
      chk("run_timeout", got_done, 1);
      chk("produced_total", produced, n);
      chk("popped_total", popped, n);
      chk("leftover_tokens", exp_q.size(), 0);
      @(posedge clk_i); #1;
      m_ready_i = 1'b0;
      @(negedge clk_i);
      chk("busy_after_done", busy_o, 0);
      chk("done_single_pulse", done_o, 0);
      $display("run n=%0d valid%%=%0d ready%%=%0d: produced=%0d popped=%0d cycles=%0d",
               n, valid_pct, ready_pct, produced, popped, cyc);
    end else begin
      $display("run n=%0d aborted by reset at cycle %0d", n, cyc);
    end
  endtask

  initial begin
    // Reset state
    rst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_all_zero("reset");
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;

    // Three tokens, downstream always ready
    forced_q = '{32'h11, 32'h22, 32'h33};
    run(3, 100, 100, 0, -1, -1, -1, 0);

    // Downstream stalled: only DEPTH tokens may be taken, then all 8 drain
    run(8, 100, 100, 12, -1, -1, 12, DEPTH);

    // Stalled array holding 0xAB with valid high must yield it once only
    forced_q = '{32'h01, 32'h02, 32'h03, 32'hAB, 32'h05, 32'h06};
    run(6, 100, 100, 10, -1, -1, -1, 0);

    // Zero-length run
    run(0, 100, 100, 0, -1, -1, -1, 0);

    // Reset mid-run with two words buffered, then a clean one-word run
    run(6, 100, 100, 20, -1, 3, -1, 0);
    run(1, 100, 100, 0, -1, -1, -1, 0);

    // Spurious start during RUN with another count is ignored
    run(5, 100, 60, 0, 2, -1, -1, 0);

    // Randomised runs
    for (int r = 0; r < 12; r++) begin
      run(int'($urandom_range(1, 20)), int'($urandom_range(40, 100)),
          int'($urandom_range(20, 100)), int'($urandom_range(0, 6)),
          int'($urandom_range(1, 8)), -1, -1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/s_pea_out_collector.md
Name: s_pea_out_collector

Overview:
Streaming-mode sink at the PE-array output edge. It captures result tokens from one PE output port (valid plus result register) and generates the array-wide `pea_ready` backpressure, so no token is lost or captured twice. It buffers tokens in a small FIFO and forwards them on a valid/ready master stream with a last marker. A programmable word count bounds each run; `done_o` pulses when the last word has been forwarded.

Parameters:
N_BITS, 32, width of PE result and stream data
DEPTH, 4, FIFO entries; must be >= 2
CNT_W, 16, width of word count and internal counters

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
start_i  in  1  start a run; sampled only in IDLE
n_words_i  in  CNT_W  number of tokens to collect in the run; sampled on start
pe_valid_i  in  1  PE output valid; held high while the array is stalled
pe_res_i  in  N_BITS  PE output result register
pea_ready_o  out  1  array advance enable, fed to every PE pea_ready_i
m_valid_o  out  1  stream data valid
m_data_o  out  N_BITS  stream data, taken from the FIFO head
m_last_o  out  1  marks the final word of the run
m_ready_i  in  1  downstream ready
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse at end of run

Behaviour:
- Reset values: all outputs 0. State IDLE, FIFO empty, all counters 0, rdy_q=0.
- rdy_q is pea_ready_o registered. PE outputs only change on an edge where pea_ready was high, so a token is new in cycle t iff rdy_q is 1.
- Capture: cap = (state==RUN) && pe_valid_i && rdy_q && (cap_cnt < n_words). cap pushes pe_res_i and increments cap_cnt.
- Stale data (pe_valid_i high while rdy_q=0) is never captured.
- pea_ready_o = (state==RUN) && (cap_cnt + cap < n_words) && (fifo_cnt + cap < DEPTH). This is combinational.
  - It reserves a slot for the token produced in response to the current ready, which arrives next cycle.
  - The pop is deliberately ignored in this term; this is conservative.
- Overflow is impossible by construction. A push when full is an assertion error.
- Stream side:
  - m_valid_o = (fifo_cnt != 0); m_data_o = head entry.
  - pop = m_valid_o && m_ready_i.
  - Data and valid stay stable until popped.
  - pop_cnt increments on pop.
  - m_last_o = m_valid_o && (pop_cnt == n_words-1).
- Simultaneous push and pop: fifo_cnt unchanged. Pop is allowed when full; push is allowed when empty.
- FIFO is a circular buffer. Read and write pointers wrap modulo DEPTH.
- FSM transitions:
  - IDLE: on start_i, latch n_words_i and clear cap_cnt, pop_cnt and rdy_q. Go to DONE if n_words_i==0, else RUN.
  - RUN: when cap_cnt reaches n_words (including the capturing cycle), go to DRAIN. pea_ready_o is already 0 from that cycle.
  - DRAIN: pea_ready_o=0. When a pop occurs with pop_cnt==n_words-1, go to DONE.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
- start_i outside IDLE is ignored. n_words_i is only sampled in IDLE.
- Latency: a token present with rdy_q=1 at cycle t is written at edge t+1 and appears on m_data_o in cycle t+1 if the FIFO was empty.
- Reset mid-run: the FIFO is flushed and all outputs return to 0 immediately (asynchronous). No done_o is generated for the aborted run.

Test Plan:
- n_words=3, PE supplies 0x11, 0x22, 0x33 on consecutive new tokens, m_ready_i=1 -> m_data_o gives 0x11, 0x22, 0x33 in order, m_last_o only with 0x33, pea_ready_o low from the 3rd capture cycle, done_o one cycle after the last pop.
- DEPTH=4, n_words=8, m_ready_i=0, new token every cycle -> exactly 4 captured, pea_ready_o=0 once fifo_cnt+cap=4. Then m_ready_i=1 -> all 8 words out in order, no loss, no duplicates.
- After a ready drop, pe_valid_i held 1 with unchanged pe_res_i=0xAB for 5 cycles -> 0xAB captured once only.
- start_i with n_words_i=0 -> busy_o for 1 cycle, done_o pulse, m_valid_o and pea_ready_o never asserted.
- Reset asserted in RUN with fifo_cnt=2 -> all outputs 0 at once. New start with n_words=1 completes normally.
- start_i pulsed during RUN with different n_words_i -> ignored, original count honoured.
